// File: rtl/corelet_ctrl.sv
// Host-side sequencer for the corelet: weight fetch, kernel load, activation fetch,
// execute, then OFIFO drain into psum SRAM with a done pulse.
module corelet_ctrl #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned row     = 8,
    parameter int unsigned addr_w  = 11,
    parameter int unsigned cnt_w   = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_w-1:0]      w_base,
    input  logic [addr_w-1:0]      a_base,
    input  logic [addr_w-1:0]      p_base,
    input  logic [cnt_w-1:0]       n_act,
    output logic                   busy,
    output logic                   done,
    output logic                   xmem_rd,
    output logic [addr_w-1:0]      xmem_addr,
    input  logic [bw*row-1:0]      xmem_rdata,
    output logic                   l0_wr,
    output logic [bw*row-1:0]      l0_wdata,
    input  logic                   l0_ready,
    output logic                   l0_rd,
    output logic [2:0]             inst_w,
    input  logic                   ofifo_valid,
    output logic                   ofifo_rd,
    input  logic [psum_bw*col-1:0] ofifo_rdata,
    output logic                   pmem_wr,
    output logic [addr_w-1:0]      pmem_addr,
    output logic [psum_bw*col-1:0] pmem_wdata
);

    localparam int unsigned cw = cnt_w + 1;
    localparam logic [cw-1:0] col_cnt = cw'(col);

    typedef enum logic [2:0] {
        StIdle,
        StWfetch,
        StKload,
        StAfetch,
        StExec,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [addr_w-1:0] w_base_q, a_base_q, p_base_q;
    logic [cnt_w-1:0]  n_act_q;
    logic [cw-1:0]     n_ext;

    // Fetch pipeline: read pointer, accepted count, L0 write count, hold slot.
    logic [cw-1:0]     rd_ptr_q, rd_ptr_d;
    logic [cw-1:0]     acc_q, acc_d;
    logic [cw-1:0]     wr_q, wr_d;
    logic              hold_full_q, hold_full_d;
    logic [bw*row-1:0] hold_q;
    logic [cw-1:0]     xmem_idx_q;
    logic              dv_q;
    logic [cw-1:0]     dv_idx_q;

    logic              xmem_rd_q, xmem_rd_d;
    logic [addr_w-1:0] xmem_addr_q, xmem_addr_d;

    logic [cw-1:0]     step_q, step_d;
    logic              l0_rd_q, l0_rd_d;
    logic [1:0]        inst_q, inst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              go;
    logic              fetch;
    logic [cw-1:0]     total;
    logic              hold_free;
    logic              arrive;
    logic              accept;
    logic              reject;
    logic              fetch_done;
    logic [cw-1:0]     rd_base;
    logic              pop;
    logic              drain_last;
    logic              kload_d;
    logic              exec_d;

    assign n_ext = {1'b0, n_act_q};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch handshake and drain datapath; independent of the next state.
    always_comb begin
        fetch      = (state_q == StWfetch) || (state_q == StAfetch);
        total      = (state_q == StWfetch) ? col_cnt : n_ext;
        l0_wr      = fetch && hold_full_q && l0_ready;
        hold_free  = !hold_full_q || l0_wr;
        // Returned data is tagged with its index; only the next expected vector is taken.
        arrive     = fetch && dv_q && (dv_idx_q == acc_q);
        accept     = arrive && hold_free;
        reject     = arrive && !hold_free;
        fetch_done = l0_wr && ((wr_q + cw'(1)) == total);
        // A refused vector is re-read from its own address, so nothing is lost.
        rd_base    = reject ? acc_q : rd_ptr_q;

        pop        = (state_q == StDrain) && ofifo_valid;
        drain_last = pop && ((step_q + cw'(1)) == n_ext);
        ofifo_rd   = pop;
        pmem_wr    = pop;
        pmem_addr  = pop ? (p_base_q + addr_w'(step_q)) : '0;
        pmem_wdata = pop ? ofifo_rdata : '0;
    end

    // Next-state logic
    always_comb begin
        go      = (state_q == StIdle) && start && !done_q;
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (go) state_d = (n_act == '0) ? StDone : StWfetch;
            StWfetch: if (fetch_done) state_d = StKload;
            StKload:  if (step_q == col_cnt) state_d = StAfetch;
            StAfetch: if (fetch_done) state_d = StExec;
            StExec:   if (step_q == n_ext) state_d = StDrain;
            StDrain:  if (drain_last) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic: next values of the registered outputs and counters.
    always_comb begin
        xmem_rd_d   = fetch && hold_free && !fetch_done && (rd_base < total);
        xmem_addr_d = ((state_q == StWfetch) ? w_base_q : a_base_q) + addr_w'(rd_base);
        rd_ptr_d    = xmem_rd_d ? (rd_base + cw'(1)) : rd_base;
        acc_d       = acc_q + cw'(accept);
        wr_d        = wr_q + cw'(l0_wr);
        hold_full_d = accept || (hold_full_q && !l0_wr);

        step_d = step_q;
        if (state_q == StKload || state_q == StExec) begin
            step_d = step_q + cw'(1);
        end else if (state_q == StDrain) begin
            step_d = step_q + cw'(pop);
        end

        if (state_d != state_q) begin
            rd_ptr_d    = '0;
            acc_d       = '0;
            wr_d        = '0;
            hold_full_d = 1'b0;
            xmem_rd_d   = 1'b0;
            step_d      = '0;
        end

        kload_d = (state_d == StKload) && (step_d < col_cnt);
        exec_d  = (state_d == StExec) && (step_d < n_ext);
        l0_rd_d = kload_d || exec_d;
        inst_d  = {exec_d, kload_d};
        busy_d  = (state_d != StIdle);
        done_d  = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_base_q    <= '0;
            a_base_q    <= '0;
            p_base_q    <= '0;
            n_act_q     <= '0;
            rd_ptr_q    <= '0;
            acc_q       <= '0;
            wr_q        <= '0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            xmem_idx_q  <= '0;
            dv_q        <= 1'b0;
            dv_idx_q    <= '0;
            xmem_rd_q   <= 1'b0;
            xmem_addr_q <= '0;
            step_q      <= '0;
            l0_rd_q     <= 1'b0;
            inst_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (go) begin
                w_base_q <= w_base;
                a_base_q <= a_base;
                p_base_q <= p_base;
                n_act_q  <= n_act;
            end
            rd_ptr_q    <= rd_ptr_d;
            acc_q       <= acc_d;
            wr_q        <= wr_d;
            hold_full_q <= hold_full_d;
            if (accept) begin
                hold_q <= xmem_rdata;
            end
            if (xmem_rd_d) begin
                xmem_idx_q  <= rd_base;
                xmem_addr_q <= xmem_addr_d;
            end
            dv_q      <= xmem_rd_q;
            dv_idx_q  <= xmem_idx_q;
            xmem_rd_q <= xmem_rd_d;
            step_q    <= step_d;
            l0_rd_q   <= l0_rd_d;
            inst_q    <= inst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign xmem_rd   = xmem_rd_q;
    assign xmem_addr = xmem_addr_q;
    assign l0_wdata  = hold_q;
    assign l0_rd     = l0_rd_q;
    assign inst_w    = {1'b0, inst_q};

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl: table of passes against a transaction-level model
// of memories and OFIFO, plus reset and start-while-busy sequences.
module tb_corelet_ctrl;

    localparam int AW = 11;
    localparam int XW = 32;
    localparam int PW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] w_base, a_base, p_base;
    logic [6:0]    n_act;
    logic          busy, done, xmem_rd, l0_wr, l0_ready, l0_rd, ofifo_valid, ofifo_rd, pmem_wr;
    logic [AW-1:0] xmem_addr, pmem_addr;
    logic [XW-1:0] xmem_rdata, l0_wdata;
    logic [2:0]    inst_w;
    logic [PW-1:0] ofifo_rdata, pmem_wdata;

    corelet_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .a_base(a_base), .p_base(p_base), .n_act(n_act),
        .busy(busy), .done(done),
        .xmem_rd(xmem_rd), .xmem_addr(xmem_addr), .xmem_rdata(xmem_rdata),
        .l0_wr(l0_wr), .l0_wdata(l0_wdata), .l0_ready(l0_ready), .l0_rd(l0_rd),
        .inst_w(inst_w),
        .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .ofifo_rdata(ofifo_rdata),
        .pmem_wr(pmem_wr), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w, a, p, n, rm, vm;
        int exp_first, exp_last, exp_nwr, exp_lat, sod;
    } vec_t;

    logic [XW-1:0] mem [2048];
    logic [XW-1:0] xrd;
    logic [PW-1:0] ofq[$];
    logic [PW-1:0] pushed[$];
    logic [AW-1:0] log_xaddr[$];
    logic [XW-1:0] log_l0[$];
    logic [AW-1:0] log_paddr[$];
    logic [PW-1:0] log_pdata[$];
    int ready_mode, valid_mode, cyc;
    int n_k, n_e, n_l0rd, n_done, n_viol, done_cyc;
    int errors, checks;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Environment: xmem (sync read), L0 ready pattern, OFIFO fed by execute cycles.
    initial begin : driver
        logic          vok;
        logic [PW-1:0] nrow;
        xrd = '0;
        cyc = 0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       l0_ready = 1'b1;
                1:       l0_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: l0_ready = 1'($urandom_range(0, 1));
            endcase
            case (valid_mode)
                0:       vok = 1'b1;
                1:       vok = (cyc % 2 == 0);
                default: vok = 1'($urandom_range(0, 1));
            endcase
            ofifo_valid = (ofq.size() > 0) && vok;
            ofifo_rdata = (ofq.size() > 0) ? ofq[0] : '0;
            xmem_rdata  = xrd;
            #1;
            if (l0_wr) log_l0.push_back(l0_wdata);
            if (l0_rd) n_l0rd++;
            if (inst_w == 3'b001) n_k++;
            if (inst_w == 3'b010) n_e++;
            if (inst_w[2] || (inst_w[0] && inst_w[1]) || (l0_wr && l0_rd)) n_viol++;
            if ((pmem_wr != ofifo_rd) || (pmem_wr && !ofifo_valid)) n_viol++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (pmem_wr) begin
                log_paddr.push_back(pmem_addr);
                log_pdata.push_back(pmem_wdata);
            end
            if (ofifo_rd && ofq.size() > 0) void'(ofq.pop_front());
            if (inst_w[1]) begin
                nrow = {$urandom, $urandom, $urandom, $urandom};
                ofq.push_back(nrow);
                pushed.push_back(nrow);
            end
            if (xmem_rd) begin
                log_xaddr.push_back(xmem_addr);
                xrd = mem[xmem_addr];
            end
            cyc++;
        end
    end

    task automatic run_pass(input int idx, input vec_t v, input int restart_at);
        logic [AW-1:0] exp_rd[$];
        logic [AW-1:0] ad;
        int st, got, bad;
        string t;
        t = $sformatf("pass%0d", idx);
        log_xaddr.delete(); log_l0.delete(); log_paddr.delete(); log_pdata.delete();
        ofq.delete(); pushed.delete();
        n_k = 0; n_e = 0; n_l0rd = 0; n_done = 0; n_viol = 0; done_cyc = 0;
        ready_mode = v.rm;
        valid_mode = v.vm;
        @(negedge clk);
        w_base = AW'(v.w); a_base = AW'(v.a); p_base = AW'(v.p); n_act = 7'(v.n);
        start = 1'b1;
        st = cyc;
        got = 0;
        for (int i = 1; i <= 3000 && got == 0; i++) begin
            @(negedge clk);
            start = (restart_at > 0) && (i == restart_at);
            if (start) begin
                n_act = 7'd5; w_base = 11'd300; a_base = 11'd400; p_base = 11'd500;
            end
            #2;
            if (n_done > 0) got = 1;
        end
        chk({t, "_done_seen"}, got, 1);
        if (got != 0 && v.sod != 0) begin
            start = 1'b1;
            n_act = 7'd3;
            @(negedge clk);
            start = 1'b0;
            #2;
            chk({t, "_start_on_done_ignored_busy"}, busy, 0);
        end
        repeat (4) @(negedge clk);
        #2;
        // Reference: weight vectors then activation vectors, addresses mod 2**11.
        if (v.n != 0) begin
            for (int i = 0; i < 8; i++) begin
                ad = AW'(v.w + i);
                exp_rd.push_back(ad);
            end
            for (int j = 0; j < v.n; j++) begin
                ad = AW'(v.a + j);
                exp_rd.push_back(ad);
            end
        end
        chk({t, "_l0_wr_count"}, log_l0.size(), exp_rd.size());
        bad = 0;
        for (int i = 0; i < log_l0.size() && i < exp_rd.size(); i++)
            if (log_l0[i] != mem[exp_rd[i]]) bad++;
        chk({t, "_l0_data_errs"}, bad, 0);
        if (v.rm == 0) begin
            bad = (log_xaddr.size() != exp_rd.size()) ? 1 : 0;
            for (int i = 0; i < log_xaddr.size() && i < exp_rd.size(); i++)
                if (log_xaddr[i] != exp_rd[i]) bad++;
            chk({t, "_xmem_addr_errs"}, bad, 0);
        end
        chk({t, "_kload_cycles"}, n_k, (v.n != 0) ? 8 : 0);
        chk({t, "_exec_cycles"}, n_e, v.n);
        chk({t, "_l0_rd_cycles"}, n_l0rd, (v.n != 0) ? 8 + v.n : 0);
        chk({t, "_pmem_writes"}, log_paddr.size(), v.exp_nwr);
        bad = 0;
        for (int k = 0; k < log_paddr.size(); k++) begin
            ad = AW'(v.p + k);
            if (log_paddr[k] != ad) bad++;
            if (k >= pushed.size() || log_pdata[k] != pushed[k]) bad++;
        end
        chk({t, "_pmem_errs"}, bad, 0);
        if (v.exp_nwr > 0 && log_paddr.size() > 0) begin
            chk({t, "_pmem_first"}, log_paddr[0], v.exp_first);
            chk({t, "_pmem_last"}, log_paddr[log_paddr.size()-1], v.exp_last);
        end
        chk({t, "_done_pulses"}, n_done, 1);
        chk({t, "_protocol_violations"}, n_viol, 0);
        chk({t, "_busy_after"}, busy, 0);
        if (v.exp_lat != 0) chk({t, "_done_latency"}, done_cyc - st, v.exp_lat);
    endtask

    initial begin : main
        vec_t tv[9];
        int   got;
        logic anyout;
        errors = 0;
        checks = 0;
        tv[0] = '{w:0,  a:16,   p:100,  n:36, rm:0, vm:0, exp_first:100,  exp_last:135,
                  exp_nwr:36, exp_lat:0, sod:0};
        tv[1] = '{w:8,  a:200,  p:300,  n:10, rm:1, vm:0, exp_first:300,  exp_last:309,
                  exp_nwr:10, exp_lat:0, sod:0};
        tv[2] = '{w:0,  a:16,   p:100,  n:36, rm:0, vm:1, exp_first:100,  exp_last:135,
                  exp_nwr:36, exp_lat:0, sod:0};
        tv[3] = '{w:5,  a:6,    p:7,    n:0,  rm:0, vm:0, exp_first:0,    exp_last:0,
                  exp_nwr:0,  exp_lat:2, sod:1};
        tv[4] = '{w:40, a:2045, p:2046, n:4,  rm:0, vm:0, exp_first:2046, exp_last:1,
                  exp_nwr:4,  exp_lat:0, sod:0};
        for (int i = 5; i < 9; i++) begin
            tv[i].w  = int'($urandom_range(0, 2047));
            tv[i].a  = int'($urandom_range(0, 2047));
            tv[i].p  = int'($urandom_range(0, 2047));
            tv[i].n  = int'($urandom_range(1, 40));
            tv[i].rm = int'($urandom_range(0, 2));
            tv[i].vm = int'($urandom_range(0, 2));
            tv[i].exp_first = tv[i].p;
            tv[i].exp_last  = (tv[i].p + tv[i].n - 1) % 2048;
            tv[i].exp_nwr   = tv[i].n;
            tv[i].exp_lat   = 0;
            tv[i].sod       = 0;
        end
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;

        reset = 1'b0; start = 1'b0; ready_mode = 0; valid_mode = 0;
        w_base = '0; a_base = '0; p_base = '0; n_act = '0;
        repeat (3) @(negedge clk);
        #2;
        anyout = |{busy, done, xmem_rd, xmem_addr, l0_wr, l0_wdata, l0_rd, inst_w,
                   ofifo_rd, pmem_wr, pmem_addr, pmem_wdata};
        chk("reset_outputs_zero", anyout, 0);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("idle_busy_after_reset", busy, 0);

        for (int i = 0; i < 9; i++) run_pass(i, tv[i], 0);
        // Second start while busy carries different parameters; it must change nothing.
        run_pass(9, tv[0], 20);

        // Reset in the middle of execute.
        ofq.delete();
        @(negedge clk);
        w_base = 11'd0; a_base = 11'd16; p_base = 11'd100; n_act = 7'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 400 && got == 0; i++) begin
            @(negedge clk);
            #2;
            if (inst_w == 3'b010) got = 1;
        end
        chk("midexec_reached", got, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        anyout = |{busy, done, xmem_rd, xmem_addr, l0_wr, l0_wdata, l0_rd, inst_w,
                   ofifo_rd, pmem_wr, pmem_addr, pmem_wdata};
        chk("midexec_reset_outputs_zero", anyout, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_done = 0;
        repeat (80) @(negedge clk);
        #2;
        chk("midexec_no_done_after_reset", n_done, 0);
        chk("midexec_idle_busy", busy, 0);
        run_pass(10, tv[4], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
